ksa: RTL and testbench
======================

KSA -- requirements
Module: ksa

Interface
REQ-001 clk  input  1  single clock; all state changes on the rising edge.
REQ-002 rst  input  1  reset, synchronous and active-high.
REQ-003 en  input  1  start request; sampled only while rdy=1.
REQ-004 key  input  24  cipher key; byte 0 is key[23:16], byte 1 is key[15:8], byte 2 is key[7:0].
REQ-005 rdddata  input  8  S-memory read data; valid the cycle after addr is presented with wren=0.
REQ-006 rdy  output  1  high only when idle and able to accept en.
REQ-007 addr  output  8  S-memory address.
REQ-008 wrdata  output  8  S-memory write data.
REQ-009 wren  output  1  S-memory write enable; one write per cycle while high.

Function
REQ-010 ksa SHALL run the ARC4 key schedule on an S memory already holding S[i]=i: j=0; for i=0..255: j=(j+S[i]+key byte[i mod 3]) mod 256, then swap S[i] and S[j].
REQ-011 States SHALL be IDLE, RD_I, CAP_I, RD_J, CAP_J, WR_I and WR_J.
REQ-012 IDLE: rdy=1, wren=0; en=1 SHALL latch key, clear i and j, and go to RD_I; en=0 SHALL stay in IDLE.
REQ-013 RD_I: addr=i, wren=0; next state CAP_I.
REQ-014 CAP_I: latch si=rddata and j=(j+rddata+key byte[i mod 3]) mod 256 (8-bit wrap); next state RD_J.
REQ-015 RD_J: addr=j (updated value), wren=0; next state CAP_J.
REQ-016 CAP_J: latch sj=rddata; next state WR_I.
REQ-017 WR_I: addr=i, wrdata=sj, wren=1; next state WR_J.
REQ-018 WR_J: addr=j, wrdata=si, wren=1; if i=255 go to IDLE, else i=i+1 and go to RD_I.
REQ-019 Each iteration SHALL take exactly 6 cycles, 1536 cycles in total.
REQ-020 If en is sampled at edge k, rdy SHALL be 0 for cycles k+1..k+1536 and 1 from cycle k+1537 on.
REQ-021 en and key changes while rdy=0 SHALL be ignored; the latched key SHALL be used for the whole run.
REQ-022 When i=j, the writes SHALL still occur as specified, and S[i] SHALL end unchanged.
REQ-023 i SHALL be 8 bits and SHALL NOT wrap; termination is detected at i=255 in WR_J.
REQ-024 The key byte index SHALL be i mod 3, kept as a 0..2 counter and not as a divider.
REQ-025 wren SHALL be 1 only in WR_I and WR_J.
REQ-026 In IDLE, addr and wrdata SHALL be 0.

Reset
REQ-027 rst=1 at any clock edge SHALL force the following on the next cycle: IDLE, rdy=1, wren=0, addr=0, wrdata=0, i=0, j=0, si=0, sj=0, latched key=0.
REQ-028 Reset mid-run SHALL abort with no further writes; memory contents are left partially scheduled, and a new en starts a fresh run.
REQ-029 rst SHALL take priority over en in the same cycle.

Verification
REQ-030 Handshake timing: preload S=identity, key=0x00033C, pulse en in IDLE -> rdy=0 for exactly 1536 cycles, then rdy=1; exactly 512 cycles with wren=1.
REQ-031 First iterations, key=0x00033C:
- i=0: writes addr0<=0, then addr0<=0.
- i=1: j=4; writes addr1<=4, then addr4<=1.
REQ-032 i=j case, key=0x000000: i=0, j=0 -> two writes of 0 to addr0; i=1, j=1 -> two writes of 1 to addr1.
REQ-033 Busy behaviour: hold en=1 and change key during a run -> no restart, and the final S matches the first key.
REQ-034 Reset mid-run: assert rst during cycle 700 -> rdy=1 and wren=0 the next cycle with no writes after; re-preload and start -> correct final S.
REQ-035 End-to-end: for random keys, the final 256 S bytes SHALL match a software ARC4 KSA model byte-for-byte.

Source files
------------

// File: rtl/ksa.sv
// ARC4 key-schedule engine: walks an external identity-initialised S memory,
// one read-read-write-write iteration per index, six cycles per index.
module ksa (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] key,
    input  logic [7:0]  rdddata,
    output logic        rdy,
    output logic [7:0]  addr,
    output logic [7:0]  wrdata,
    output logic        wren
);

    typedef enum logic [2:0] {
        IDLE,
        RD_I,
        CAP_I,
        RD_J,
        CAP_J,
        WR_I,
        WR_J
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  i_q, i_d;
    logic [7:0]  j_q, j_d;
    logic [7:0]  si_q, si_d;
    logic [7:0]  sj_q, sj_d;
    logic [23:0] key_q, key_d;
    logic [1:0]  kidx_q, kidx_d;

    // Byte 0 of the key sits in the most significant byte.
    function automatic logic [7:0] key_byte(input logic [23:0] k, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = k[23:16];
            2'd1:    b = k[15:8];
            2'd2:    b = k[7:0];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        si_d    = si_q;
        sj_d    = sj_q;
        key_d   = key_q;
        kidx_d  = kidx_q;
        rdy     = 1'b0;
        addr    = 8'd0;
        wrdata  = 8'd0;
        wren    = 1'b0;

        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    key_d   = key;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    kidx_d  = 2'd0;
                    state_d = RD_I;
                end
            end
            RD_I: begin
                addr    = i_q;
                state_d = CAP_I;
            end
            CAP_I: begin
                si_d    = rdddata;
                j_d     = j_q + rdddata + key_byte(key_q, kidx_q);
                state_d = RD_J;
            end
            RD_J: begin
                addr    = j_q;
                state_d = CAP_J;
            end
            CAP_J: begin
                sj_d    = rdddata;
                state_d = WR_I;
            end
            WR_I: begin
                addr    = i_q;
                wrdata  = sj_q;
                wren    = 1'b1;
                state_d = WR_J;
            end
            WR_J: begin
                addr   = j_q;
                wrdata = si_q;
                wren   = 1'b1;
                // i stops at 255 rather than wrapping; that is the end-of-run marker.
                if (i_q == 8'hFF) begin
                    state_d = IDLE;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
                    state_d = RD_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            key_q   <= 24'd0;
            kidx_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            key_q   <= key_d;
            kidx_q  <= kidx_d;
        end
    end

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: S memory model, software ARC4 key schedule as reference,
// one negedge compare process covering handshake, write stream and final S.
module tb_ksa;

    logic        clk;
    logic        rst;
    logic        en;
    logic [23:0] key;
    logic [7:0]  rdddata;
    logic        rdy;
    logic [7:0]  addr;
    logic [7:0]  wrdata;
    logic        wren;

    logic        preload;
    logic [7:0]  mem [256];
    logic [7:0]  rd_q;

    logic [7:0]  exp_s [256];
    logic [15:0] exp_w [512];

    int total;
    int bad;

    ksa dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .key     (key),
        .rdddata (rdddata),
        .rdy     (rdy),
        .addr    (addr),
        .wrdata  (wrdata),
        .wren    (wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read S memory; preload restores the identity permutation.
    always @(posedge clk) begin
        if (preload) begin
            for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
        end else if (wren) begin
            mem[addr] <= wrdata;
        end
        rd_q <= mem[addr];
    end
    assign rdddata = rd_q;

    // Software ARC4 KSA: final permutation plus the ordered list of writes.
    task automatic build_model(input logic [23:0] k);
        logic [7:0] s [256];
        logic [7:0] kb [3];
        logic [7:0] t;
        int j;
        kb[0] = k[23:16];
        kb[1] = k[15:8];
        kb[2] = k[7:0];
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(s[i]) + int'(kb[i % 3])) % 256;
            exp_w[2*i]   = {8'(i), s[j]};
            exp_w[2*i+1] = {8'(j), s[i]};
            t    = s[i];
            s[i] = s[j];
            s[j] = t;
        end
        for (int n = 0; n < 256; n++) exp_s[n] = s[n];
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: decisions taken at one negedge apply after the next posedge.
    initial begin : compare
        bit active;
        bit pend_rst;
        bit pend_start;
        int cyc;
        int widx;
        total = 0;
        bad   = 0;
        active = 0;
        pend_rst = 0;
        pend_start = 0;
        cyc = 0;
        widx = 0;

        build_model(24'h00033C);
        check("pin_33c_w0", 32'(exp_w[0]), 32'h0000);
        check("pin_33c_w1", 32'(exp_w[1]), 32'h0000);
        check("pin_33c_w2", 32'(exp_w[2]), 32'h0104);
        check("pin_33c_w3", 32'(exp_w[3]), 32'h0401);
        build_model(24'h000000);
        check("pin_k0_w0", 32'(exp_w[0]), 32'h0000);
        check("pin_k0_w1", 32'(exp_w[1]), 32'h0000);
        check("pin_k0_w2", 32'(exp_w[2]), 32'h0101);
        check("pin_k0_w3", 32'(exp_w[3]), 32'h0101);
        check("pin_k0_w4", 32'(exp_w[4]), 32'h0203);

        forever begin
            @(negedge clk);
            if (pend_rst) begin
                active = 0;
                check("reset_outputs", 32'({rdy, wren, addr, wrdata}), 32'({1'b1, 1'b0, 8'd0, 8'd0}));
            end else begin
                if (pend_start) begin
                    active = 1;
                    cyc = 0;
                    widx = 0;
                end
                if (active) begin
                    cyc++;
                    if (cyc <= 1536) begin
                        check("rdy_busy", 32'(rdy), 32'(0));
                        if (wren) begin
                            check("write", 32'({addr, wrdata}),
                                  (widx < 512) ? 32'(exp_w[widx]) : 32'hFFFF_FFFF);
                            widx++;
                        end
                    end else begin
                        check("wren_cycles", 32'(widx), 32'(512));
                        for (int n = 0; n < 256; n++)
                            check("final_s", 32'({8'(n), mem[n]}), 32'({8'(n), exp_s[n]}));
                        active = 0;
                    end
                end
                if (!active)
                    check("idle_outputs", 32'({rdy, wren, addr, wrdata}), 32'({1'b1, 1'b0, 8'd0, 8'd0}));
            end
            pend_rst   = rst;
            pend_start = !rst && rdy && en;
            if (pend_start) build_model(key);
        end
    end

    // All stimulus changes happen 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_preload();
        preload = 1'b1;
        tick(1);
        preload = 1'b0;
    endtask

    task automatic start_run(input logic [23:0] k, input bit hold);
        key = k;
        en  = 1'b1;
        tick(1);
        if (!hold) en = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 3000 && !rdy; n++) tick(1);
        tick(3);
    endtask

    initial begin : stim
        rst = 1'b1;
        en = 1'b0;
        key = 24'd0;
        preload = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);

        do_preload();
        start_run(24'h00033C, 1'b0);
        wait_idle();

        do_preload();
        start_run(24'h000000, 1'b0);
        wait_idle();

        // Busy: en held and key changed mid-run must not disturb the run.
        do_preload();
        start_run(24'hA5C31F, 1'b1);
        tick(100);
        key = 24'h123456;
        tick(1390);
        en = 1'b0;
        wait_idle();

        // Abort during cycle 700 of a run, then a fresh run.
        do_preload();
        start_run(24'h5AF00D, 1'b0);
        tick(698);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(10);
        do_preload();
        start_run(24'h5AF00D, 1'b0);
        wait_idle();

        for (int r = 0; r < 2; r++) begin
            do_preload();
            start_run(24'($urandom), 1'b0);
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
